// File: rtl/ecc_176_pkg.sv
// Shared SECDED definitions for the 176-bit FIFO word (write-side encoder and read-side decoder).
// H-matrix: data bit i sits at the i-th non-power-of-two Hamming position starting at 3.
package ecc_176_pkg;

  localparam int DATA_WIDTH   = 176;
  localparam int HAM_WIDTH    = 8;
  localparam int PARITY_WIDTH = HAM_WIDTH + 1;

  localparam logic [1:0] INJ_NONE = 2'b00;
  localparam logic [1:0] INJ_SBIT = 2'b01;
  localparam logic [1:0] INJ_DBIT = 2'b10;

  localparam logic [7:0] INJ_POS_MAX = 8'(DATA_WIDTH - 1);

  typedef logic [HAM_WIDTH-1:0][DATA_WIDTH-1:0] hmask_t;

  function automatic hmask_t gen_h_mask();
    hmask_t      m;
    int unsigned pos;
    m   = '0;
    pos = 3;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      for (int j = 0; j < HAM_WIDTH; j++) m[j][i] = pos[j];
      pos++;
    end
    return m;
  endfunction

  localparam hmask_t H_MASK = gen_h_mask();

  // Out-of-range injection positions fold onto bit 0.
  function automatic logic [7:0] inj_pos_clamp(input logic [7:0] pos);
    return (pos > INJ_POS_MAX) ? 8'd0 : pos;
  endfunction

endpackage

// File: rtl/ecc_176_enc_fault_detc_if.sv
// Word stream into and out of the encoder stage (valid/ready on both sides).
interface ecc_176_enc_fault_detc_if;
  import ecc_176_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   data_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   data_out;
  logic [PARITY_WIDTH-1:0] parity_out;
  logic                    out_fault;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, parity_out, out_fault
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, parity_out, out_fault
  );

endinterface

// File: rtl/ecc_176_enc.sv
// Combinational SECDED check-bit generator: 8 Hamming bits plus overall parity in bit 8.
module ecc_176_enc
  import ecc_176_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [PARITY_WIDTH-1:0] parity_o
);

  logic [HAM_WIDTH-1:0] ham;

  always_comb begin
    ham = '0;
    for (int j = 0; j < HAM_WIDTH; j++) ham[j] = ^(data_i & H_MASK[j]);
  end

  assign parity_o = {(^data_i) ^ (^ham), ham};

endmodule

// File: rtl/ecc_176_enc_fault_detc.sv
// Write-side SECDED encoder with duplicated parity generation and compare, one valid/ready
// register stage, fault status/counter and one-shot data-bit injection.
module ecc_176_enc_fault_detc
  import ecc_176_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ecc_fault_detc_en,
  input  logic                 bypass,
  ecc_176_enc_fault_detc_if.slave bus,
  output logic                 ecc_fault,
  output logic                 fault_sticky,
  output logic [CNT_WIDTH-1:0] fault_cnt,
  input  logic                 fault_clr,
  input  logic                 fault_test,
  input  logic                 inj_arm,
  input  logic [1:0]           inj_mode,
  input  logic [7:0]           inj_pos,
  output logic                 inj_busy
);

  logic [PARITY_WIDTH-1:0] par0, par1_raw, par1;
  logic                    accept, mismatch, arm_ok;
  logic [1:0]              eff_mode;
  logic [7:0]              eff_pos, eff_pos_nxt;
  logic [DATA_WIDTH-1:0]   flip;

  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic [PARITY_WIDTH-1:0] parity_out_q, parity_out_d;
  logic                    out_fault_q, out_fault_d;
  logic                    ecc_fault_q, ecc_fault_d;
  logic                    sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    inj_busy_q, inj_busy_d;
  logic [1:0]              inj_mode_q, inj_mode_d;
  logic [7:0]              inj_pos_q, inj_pos_d;

  ecc_176_enc u_enc0 (.data_i(bus.data_in), .parity_o(par0));
  ecc_176_enc u_enc1 (.data_i(bus.data_in), .parity_o(par1_raw));

  // Self-test perturbs only the checking copy so parity_out stays correct.
  assign par1 = par1_raw ^ {{(PARITY_WIDTH-1){1'b0}}, fault_test};

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign mismatch     = (par0 != par1) & ecc_fault_detc_en & ~bypass;
  assign arm_ok       = inj_arm & ~inj_busy_q & ((inj_mode == INJ_SBIT) | (inj_mode == INJ_DBIT));

  always_comb begin
    // An already-armed injection wins; otherwise a same-cycle arm applies to this word.
    eff_mode    = inj_busy_q ? inj_mode_q : (arm_ok ? inj_mode : INJ_NONE);
    eff_pos     = inj_busy_q ? inj_pos_q : inj_pos_clamp(inj_pos);
    eff_pos_nxt = (eff_pos == INJ_POS_MAX) ? 8'd0 : eff_pos + 8'd1;
    flip        = '0;
    if (eff_mode == INJ_SBIT || eff_mode == INJ_DBIT) flip[eff_pos] = 1'b1;
    if (eff_mode == INJ_DBIT) flip[eff_pos_nxt] = 1'b1;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    data_out_d   = data_out_q;
    parity_out_d = parity_out_q;
    out_fault_d  = out_fault_q;
    ecc_fault_d  = accept & mismatch;
    sticky_d     = sticky_q;
    cnt_d        = cnt_q;
    inj_busy_d   = inj_busy_q;
    inj_mode_d   = inj_mode_q;
    inj_pos_d    = inj_pos_q;

    if (accept) begin
      out_valid_d  = 1'b1;
      data_out_d   = bus.data_in ^ flip;
      parity_out_d = bypass ? '0 : par0;
      out_fault_d  = mismatch;
    end else if (bus.out_ready) begin
      out_valid_d  = 1'b0;
    end

    if (accept && (inj_busy_q || arm_ok)) begin
      inj_busy_d = 1'b0;
    end else if (arm_ok) begin
      inj_busy_d = 1'b1;
      inj_mode_d = inj_mode;
      inj_pos_d  = inj_pos_clamp(inj_pos);
    end

    if (fault_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (ecc_fault_q) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
      parity_out_q <= '0;
      out_fault_q  <= 1'b0;
      ecc_fault_q  <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
      inj_busy_q   <= 1'b0;
      inj_mode_q   <= INJ_NONE;
      inj_pos_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
      parity_out_q <= parity_out_d;
      out_fault_q  <= out_fault_d;
      ecc_fault_q  <= ecc_fault_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
      inj_busy_q   <= inj_busy_d;
      inj_mode_q   <= inj_mode_d;
      inj_pos_q    <= inj_pos_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.data_out   = data_out_q;
  assign bus.parity_out = parity_out_q;
  assign bus.out_fault  = out_fault_q;
  assign ecc_fault      = ecc_fault_q;
  assign fault_sticky   = sticky_q;
  assign fault_cnt      = cnt_q;
  assign inj_busy       = inj_busy_q;

endmodule

// File: tb/tb_ecc_176_enc_fault_detc.sv
// Bench for ecc_176_enc_fault_detc: random streams against a position-XOR SECDED model and decoder.
module tb_ecc_176_enc_fault_detc;
  import ecc_176_pkg::*;

  logic       clk = 1'b0;
  logic       rst, ecc_fault_detc_en, bypass, fault_clr, fault_test, inj_arm;
  logic [1:0] inj_mode;
  logic [7:0] inj_pos;
  logic       ecc_fault, fault_sticky, inj_busy;
  logic [7:0] fault_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [175:0] d;
    logic [8:0]   p;
    logic         f;
  } exp_t;

  logic [7:0] hpos [176];

  always #5 clk = ~clk;

  ecc_176_enc_fault_detc_if bus();

  ecc_176_enc_fault_detc #(.CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ecc_fault_detc_en(ecc_fault_detc_en), .bypass(bypass),
    .bus(bus), .ecc_fault(ecc_fault), .fault_sticky(fault_sticky), .fault_cnt(fault_cnt),
    .fault_clr(fault_clr), .fault_test(fault_test), .inj_arm(inj_arm), .inj_mode(inj_mode),
    .inj_pos(inj_pos), .inj_busy(inj_busy)
  );

  // Syndrome of a word is the XOR of the Hamming positions of its set data bits.
  function automatic logic [8:0] ref_parity(input logic [175:0] d);
    logic [7:0] syn;
    logic       ov;
    syn = 8'd0;
    ov  = 1'b0;
    for (int i = 0; i < 176; i++) if (d[i]) begin syn ^= hpos[i]; ov = ~ov; end
    return {ov ^ (^syn), syn};
  endfunction

  task automatic decode(input logic [175:0] d, input logic [8:0] p,
                        output logic sbe, output logic dbe, output logic [175:0] fixed);
    logic [8:0] rp;
    logic [7:0] syn;
    rp    = ref_parity(d);
    syn   = rp[7:0] ^ p[7:0];
    sbe   = (^d) ^ (^p);
    dbe   = ~sbe & (syn != 8'd0);
    fixed = d;
    if (sbe) for (int i = 0; i < 176; i++) if (hpos[i] == syn) fixed[i] = ~fixed[i];
  endtask

  function automatic logic [175:0] rand176();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[175:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1; ecc_fault_detc_en = 0; bypass = 0; fault_clr = 0; fault_test = 0;
    inj_arm = 0; inj_mode = 2'b00; inj_pos = 8'd0;
    bus.in_valid = 0; bus.data_in = '0; bus.out_ready = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({bus.out_valid, bus.out_fault, ecc_fault, fault_sticky, inj_busy, fault_cnt} !== 13'd0) begin
      failures++; $display("FAIL reset_flags: got %0h expected 0", {bus.out_valid, bus.out_fault, ecc_fault, fault_sticky, inj_busy, fault_cnt}); end
    checks++; if (bus.data_out !== 176'd0 || bus.parity_out !== 9'd0) begin
      failures++; $display("FAIL reset_data: got %0h/%0h expected 0/0", bus.data_out, bus.parity_out); end
    checks++; if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_zero_word();
    @(negedge clk); bus.in_valid = 1; bus.data_in = '0; bus.out_ready = 1;
    @(negedge clk); bus.in_valid = 0; #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== 176'd0 || bus.parity_out !== 9'h000 || ecc_fault !== 1'b0) begin
      failures++; $display("FAIL zero_word: got v=%0b d=%0h p=%0h f=%0b expected 1/0/0/0", bus.out_valid, bus.data_out, bus.parity_out, ecc_fault); end
  endtask

  task automatic run_stream(input string name, input int n, input int vpct, input int rpct,
                            input logic en, input logic ft, input logic byp,
                            output int pulses, output int cyc);
    exp_t         q[$];
    exp_t         e;
    int           pushed, popped;
    logic         prev_mm, sbe, dbe;
    logic [175:0] fx;
    pushed = 0; popped = 0; pulses = 0; cyc = 0; prev_mm = 0;
    @(negedge clk);
    ecc_fault_detc_en = en; fault_test = ft; bypass = byp; bus.in_valid = 0;
    while (popped < n && cyc < 20 * n + 50) begin
      @(negedge clk);
      checks++; if (ecc_fault !== prev_mm) begin
        failures++; $display("FAIL %s_pulse: got %0b expected %0b at cycle %0d", name, ecc_fault, prev_mm, cyc); end
      bus.out_ready = ($urandom_range(99) < rpct);
      if (pushed < n && $urandom_range(99) < vpct) begin bus.in_valid = 1; bus.data_in = rand176(); end
      else bus.in_valid = 0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++; failures++; $display("FAIL %s_extra: got unexpected word %0h expected none", name, bus.data_out);
        end else begin
          e = q.pop_front(); popped++;
          checks++; if (bus.data_out !== e.d || bus.parity_out !== e.p || bus.out_fault !== e.f) begin
            failures++; $display("FAIL %s_word: got %0h %0h %0b expected %0h %0h %0b", name, bus.data_out, bus.parity_out, bus.out_fault, e.d, e.p, e.f); end
          if (!byp) begin
            decode(bus.data_out, bus.parity_out, sbe, dbe, fx);
            checks++; if (sbe !== 1'b0 || dbe !== 1'b0 || fx !== e.d) begin
              failures++; $display("FAIL %s_decode: got sbe=%0b dbe=%0b d=%0h expected 0 0 %0h", name, sbe, dbe, fx, e.d); end
          end
        end
      end
      prev_mm = 0;
      if (bus.in_valid && bus.in_ready) begin
        e.d = bus.data_in;
        e.p = byp ? 9'd0 : ref_parity(bus.data_in);
        e.f = en & ft & ~byp;
        q.push_back(e); pushed++;
        prev_mm = e.f;
        if (e.f) pulses++;
      end
      cyc++;
    end
    checks++; if (popped != n) begin
      failures++; $display("FAIL %s_timeout: got %0d words expected %0d", name, popped, n); end
    @(negedge clk);
    bus.in_valid = 0; bus.out_ready = 1;
    checks++; if (ecc_fault !== prev_mm) begin
      failures++; $display("FAIL %s_last_pulse: got %0b expected %0b", name, ecc_fault, prev_mm); end
  endtask

  task automatic test_random_stream();
    int p, c;
    run_stream("random", 60, 60, 60, 0, 0, 0, p, c);
  endtask

  task automatic test_back_to_back();
    int p, c;
    run_stream("b2b", 40, 100, 100, 0, 0, 0, p, c);
    checks++; if (c != 41) begin
      failures++; $display("FAIL b2b_throughput: got %0d cycles expected 41", c); end
  endtask

  task automatic test_backpressure();
    logic [175:0] a, b;
    a = rand176(); b = rand176();
    @(negedge clk); bus.out_ready = 0; bus.in_valid = 1; bus.data_in = a;
    @(negedge clk); bus.data_in = b;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.data_out !== a) begin
        failures++; $display("FAIL bp_hold: got rdy=%0b v=%0b d=%0h expected 0 1 %0h", bus.in_ready, bus.out_valid, bus.data_out, a); end
      if (k < 2) @(negedge clk);
    end
    @(negedge clk); bus.out_ready = 1;
    @(negedge clk); bus.in_valid = 0; #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== b) begin
      failures++; $display("FAIL bp_second: got v=%0b d=%0h expected 1 %0h", bus.out_valid, bus.data_out, b); end
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_drain: got v=%0b expected 0", bus.out_valid); end
  endtask

  task automatic test_fault_counter();
    int p, c;
    run_stream("ftest", 300, 100, 100, 1, 1, 0, p, c);
    repeat (2) @(negedge clk); #1;
    checks++; if (fault_sticky !== 1'b1 || fault_cnt !== ((p > 255) ? 8'hFF : 8'(p))) begin
      failures++; $display("FAIL ftest_cnt: got sticky=%0b cnt=%0h expected 1 %0h", fault_sticky, fault_cnt, (p > 255) ? 8'hFF : 8'(p)); end
    fault_clr = 1;
    @(negedge clk); fault_clr = 0; #1;
    checks++; if (fault_sticky !== 1'b0 || fault_cnt !== 8'd0) begin
      failures++; $display("FAIL ftest_clr: got sticky=%0b cnt=%0h expected 0 0", fault_sticky, fault_cnt); end
    @(negedge clk); bus.in_valid = 1; bus.data_in = rand176();
    @(negedge clk); bus.in_valid = 0; #1;
    checks++; if (ecc_fault !== 1'b1) begin
      failures++; $display("FAIL ftest_single_pulse: got %0b expected 1", ecc_fault); end
    fault_clr = 1;
    @(negedge clk); fault_clr = 0;
    repeat (2) @(negedge clk); #1;
    checks++; if (fault_sticky !== 1'b0 || fault_cnt !== 8'd0) begin
      failures++; $display("FAIL clr_priority: got sticky=%0b cnt=%0h expected 0 0", fault_sticky, fault_cnt); end
    run_stream("ftest_dis", 300, 100, 100, 0, 1, 0, p, c);
    repeat (2) @(negedge clk); #1;
    checks++; if (fault_sticky !== 1'b0 || fault_cnt !== 8'd0) begin
      failures++; $display("FAIL ftest_dis_cnt: got sticky=%0b cnt=%0h expected 0 0", fault_sticky, fault_cnt); end
    run_stream("bypass", 30, 70, 70, 1, 1, 1, p, c);
    repeat (2) @(negedge clk); #1;
    checks++; if (fault_cnt !== 8'd0) begin
      failures++; $display("FAIL bypass_cnt: got %0h expected 0", fault_cnt); end
    ecc_fault_detc_en = 0; fault_test = 0; bypass = 0;
  endtask

  task automatic test_inject();
    logic [175:0] d, e, fx;
    logic         sbe, dbe;
    bus.out_ready = 1;
    @(negedge clk); inj_arm = 1; inj_mode = INJ_SBIT; inj_pos = 8'd5;
    @(negedge clk); #1;
    checks++; if (inj_busy !== 1'b1) begin
      failures++; $display("FAIL inj_busy_set: got %0b expected 1", inj_busy); end
    inj_mode = INJ_DBIT; inj_pos = 8'd9;
    @(negedge clk); inj_arm = 0; bus.in_valid = 1; bus.data_in = '0;
    @(negedge clk); bus.in_valid = 0; #1;
    e = '0; e[5] = 1'b1;
    decode(bus.data_out, bus.parity_out, sbe, dbe, fx);
    checks++; if (bus.data_out !== e || bus.parity_out !== 9'h000 || inj_busy !== 1'b0) begin
      failures++; $display("FAIL inj_sbit: got d=%0h p=%0h busy=%0b expected %0h 0 0", bus.data_out, bus.parity_out, inj_busy, e); end
    checks++; if (sbe !== 1'b1 || dbe !== 1'b0 || fx !== 176'd0) begin
      failures++; $display("FAIL inj_sbit_decode: got sbe=%0b dbe=%0b d=%0h expected 1 0 0", sbe, dbe, fx); end

    d = rand176();
    @(negedge clk); inj_arm = 1; inj_mode = INJ_DBIT; inj_pos = 8'd175;
    @(negedge clk); inj_arm = 0; bus.in_valid = 1; bus.data_in = d;
    @(negedge clk); bus.in_valid = 0; #1;
    e = d; e[175] = ~e[175]; e[0] = ~e[0];
    decode(bus.data_out, bus.parity_out, sbe, dbe, fx);
    checks++; if (bus.data_out !== e || bus.parity_out !== ref_parity(d) || inj_busy !== 1'b0) begin
      failures++; $display("FAIL inj_dbit: got d=%0h p=%0h busy=%0b expected %0h %0h 0", bus.data_out, bus.parity_out, inj_busy, e, ref_parity(d)); end
    checks++; if (sbe !== 1'b0 || dbe !== 1'b1) begin
      failures++; $display("FAIL inj_dbit_decode: got sbe=%0b dbe=%0b expected 0 1", sbe, dbe); end

    d = rand176();
    @(negedge clk); inj_arm = 1; inj_mode = INJ_SBIT; inj_pos = 8'd200; bus.in_valid = 1; bus.data_in = d;
    @(negedge clk); inj_arm = 0; bus.in_valid = 0; #1;
    e = d; e[0] = ~e[0];
    checks++; if (bus.data_out !== e || bus.parity_out !== ref_parity(d) || inj_busy !== 1'b0) begin
      failures++; $display("FAIL inj_same_cycle: got d=%0h p=%0h busy=%0b expected %0h %0h 0", bus.data_out, bus.parity_out, inj_busy, e, ref_parity(d)); end

    d = rand176();
    @(negedge clk); inj_arm = 1; inj_mode = INJ_NONE; inj_pos = 8'd3;
    @(negedge clk); inj_arm = 0; bus.in_valid = 1; bus.data_in = d; #1;
    checks++; if (inj_busy !== 1'b0) begin
      failures++; $display("FAIL inj_noop_arm: got busy=%0b expected 0", inj_busy); end
    @(negedge clk); bus.in_valid = 0; #1;
    checks++; if (bus.data_out !== d) begin
      failures++; $display("FAIL inj_noop_data: got %0h expected %0h", bus.data_out, d); end

    d = rand176();
    @(negedge clk); bypass = 1; inj_arm = 1; inj_mode = INJ_SBIT; inj_pos = 8'd100; bus.in_valid = 1; bus.data_in = d;
    @(negedge clk); inj_arm = 0; bus.in_valid = 0; bypass = 0; #1;
    e = d; e[100] = ~e[100];
    checks++; if (bus.data_out !== e || bus.parity_out !== 9'd0) begin
      failures++; $display("FAIL inj_bypass: got d=%0h p=%0h expected %0h 0", bus.data_out, bus.parity_out, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [175:0] d;
    d = rand176();
    @(negedge clk); ecc_fault_detc_en = 1; fault_test = 1; bus.out_ready = 0; bus.in_valid = 1; bus.data_in = d;
    @(negedge clk); bus.in_valid = 0; inj_arm = 1; inj_mode = INJ_SBIT; inj_pos = 8'd7;
    @(negedge clk); inj_arm = 0; #1;
    checks++; if (bus.out_valid !== 1'b1 || inj_busy !== 1'b1 || fault_sticky !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre: got v=%0b busy=%0b sticky=%0b expected 1 1 1", bus.out_valid, inj_busy, fault_sticky); end
    rst = 1;
    @(negedge clk); rst = 0; #1;
    checks++; if ({bus.out_valid, bus.out_fault, ecc_fault, fault_sticky, inj_busy, fault_cnt} !== 13'd0 ||
                  bus.data_out !== 176'd0 || bus.parity_out !== 9'd0) begin
      failures++; $display("FAIL rst_mid: got flags=%0h d=%0h p=%0h expected 0 0 0", {bus.out_valid, bus.out_fault, ecc_fault, fault_sticky, inj_busy, fault_cnt}, bus.data_out, bus.parity_out); end
    ecc_fault_detc_en = 0; fault_test = 0; bus.out_ready = 1;
    d = rand176();
    @(negedge clk); bus.in_valid = 1; bus.data_in = d;
    @(negedge clk); bus.in_valid = 0; #1;
    checks++; if (bus.data_out !== d || bus.parity_out !== ref_parity(d)) begin
      failures++; $display("FAIL rst_mid_inj_dropped: got %0h %0h expected %0h %0h", bus.data_out, bus.parity_out, d, ref_parity(d)); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    p = 2;
    for (int i = 0; i < 176; i++) begin
      p++;
      while ((p & (p - 1)) == 0) p++;
      hpos[i] = 8'(p);
    end
    test_reset();
    test_zero_word();
    test_random_stream();
    test_back_to_back();
    test_backpressure();
    test_fault_counter();
    test_inject();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
